fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and sequencing stage that sits directly upstream of the instruction decoder. It holds the program counter and requests 16-bit instruction words from instruction memory over a request/valid handshake. It latches each word into an instruction register and presents it to the decoder with an active-low decode strobe. It then holds the instruction through execute until the datapath releases it, applying any branch redirect before the next fetch.

## Interface
Parameters:
- ADDR_W, 16, program counter and memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (fixed: one clock; reset is asynchronous and active-low).
- run  input  1  level; 1 permits fetching, 0 parks the FSM in IDLE after the current instruction.
- resume  input  1  one-cycle pulse; exits HALT.
- mem_req  output  1  one-cycle read request to instruction memory.
- mem_addr  output  ADDR_W  read address; valid while mem_req=1, held until the word returns.
- mem_rdata  input  16  instruction word; sampled only when mem_rvalid=1 in WAIT_MEM.
- mem_rvalid  input  1  read data valid.
- stall  input  1  datapath busy; holds EXECUTE while 1.
- branch_en  input  1  redirect request; sampled in EXECUTE on the cycle stall=0.
- branch_target  input  ADDR_W  redirect address.
- instr_set  output  16  instruction register contents feeding the decoder.
- decoder_en  output  1  active-low decode strobe; 0 only during DECODE.
- pc  output  ADDR_W  address of the next instruction to fetch.
- halted  output  1  1 while in HALT.

## Operation
- States: IDLE, FETCH, WAIT_MEM, DECODE, EXECUTE, HALT.
- IDLE: goes to FETCH when run=1; otherwise stays.
- FETCH: mem_req=1 and mem_addr=pc for exactly one cycle, then WAIT_MEM.
- WAIT_MEM: waits with no timeout. On mem_rvalid=1: instr_set<=mem_rdata, pc<=pc+1 (modulo 2^ADDR_W, so all-ones wraps to 0), then DECODE.
- DECODE: decoder_en=0 for one cycle. Goes to HALT if instr_set[15:12]=0000 and instr_set[7:4]=0000 (WAIT encoding); otherwise goes to EXECUTE.
- EXECUTE: stays while stall=1. On the first cycle with stall=0:
  - pc<=branch_target if branch_en=1.
  - Next state is FETCH if run=1, else IDLE.
- HALT: halted=1 and pc is frozen. resume=1 returns to FETCH if run=1, else IDLE.
- instr_set holds its value everywhere except the capture edge in WAIT_MEM.
- Exactly one memory request is outstanding at a time.

## Timing
- Reset values (asynchronous on reset=0):
  - state=IDLE, pc=mem_addr=RESET_PC, instr_set=16'h0000.
  - mem_req=0, decoder_en=1, halted=0.
- Zero-wait memory (rvalid the cycle after the request), no stall: 4 cycles per instruction (FETCH, WAIT_MEM, DECODE, EXECUTE).
- Each cycle of memory wait or of stall adds one cycle.
- mem_rvalid outside WAIT_MEM is ignored, including a stale response arriving after reset.
- A branch is applied only at EXECUTE exit. The PC increment from WAIT_MEM is overwritten; there is no delay slot.
- run falling during FETCH, WAIT_MEM, DECODE or EXECUTE does not abort: the instruction completes, then the FSM enters IDLE.
- resume is ignored outside HALT.
- A branch_en pulse that arrives while stall=1 is lost. Upstream must hold branch_en until stall=0.
- Reset asserted mid-operation returns all outputs to their reset values immediately and combinationally-asynchronously; a pending memory request is abandoned.

## Structure
- Shared package: state enum, WAIT_OPCODE=4'b0000, WAIT_EXT=4'b0000, opcode field positions [15:12] and [7:4].
- Natural sub-module: pc_counter (load, increment, branch load, async reset to RESET_PC).
- FSM and instruction register live in fetch_unit.

## Test plan
- Reset, run=1, memory returns 16'h5123 at address 0 with zero wait:
  - mem_req at cycle 1; instr_set=16'h5123 and decoder_en=0 at cycle 3; pc=1.
- Memory wait of 3 cycles: DECODE delayed by 3 cycles; mem_addr stable throughout; a single mem_req pulse.
- EXECUTE with stall=1 for 2 cycles, then branch_en=1, branch_target=16'h0040: next mem_addr=16'h0040; pc does not become 16'h0041 before that fetch.
- pc=16'hFFFF, fetch completes: pc wraps to 16'h0000.
- Instruction 16'h0300 (WAIT): halted=1 after DECODE, no mem_req until the resume pulse; fetch then restarts at the incremented pc.
- reset asserted during WAIT_MEM, then a late mem_rvalid arrives: it is ignored; instr_set=0, pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM states and WAIT instruction encoding for the fetch stage
package fetch_unit_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, EXECUTE, HALT} state_t;
    localparam logic [3:0] WAIT_OPCODE = 4'b0000;
    localparam logic [3:0] WAIT_EXT    = 4'b0000;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    function automatic logic is_wait(input logic [15:0] i);
        return i[OPC_HI:OPC_LO] == WAIT_OPCODE && i[EXT_HI:EXT_LO] == WAIT_EXT;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/valid read bus
interface fetch_unit_if #(parameter int ADDR_W = 16);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_rvalid;
    modport master(output mem_req, mem_addr, input mem_rdata, mem_rvalid);
    modport slave(input mem_req, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// fetch_unit_pc_counter: program counter with increment and branch load
module fetch_unit_pc_counter
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);
    // branch load wins over increment; increment wraps naturally at all-ones
    always_ff @(posedge clk or negedge reset)
        if (!reset) pc <= RESET_PC;
        else if (load) pc <= target;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch/decode/execute sequencer holding the PC and instruction register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                resume,
    fetch_unit_if.master        mem,
    input  logic                stall,
    input  logic                branch_en,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [15:0]         instr_set,
    output logic                decoder_en,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);
    state_t state;
    logic   capture;
    logic   redirect;
    assign capture       = state == WAIT_MEM && mem.mem_rvalid;
    assign redirect      = state == EXECUTE && !stall && branch_en;
    assign mem.mem_addr  = pc;
    fetch_unit_pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .inc    (capture),
        .load   (redirect),
        .target (branch_target),
        .pc     (pc)
    );
    // sequencer with outputs registered on the transition into each state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            instr_set    <= '0;
            mem.mem_req  <= 1'b0;
            decoder_en   <= 1'b1;
            halted       <= 1'b0;
        end else begin
            mem.mem_req <= 1'b0;
            decoder_en  <= 1'b1;
            case (state)
                IDLE: if (run) begin
                    state       <= FETCH;
                    mem.mem_req <= 1'b1;
                end
                FETCH: state <= WAIT_MEM;
                WAIT_MEM: if (mem.mem_rvalid) begin
                    instr_set  <= mem.mem_rdata;
                    state      <= DECODE;
                    decoder_en <= 1'b0;
                end
                DECODE: if (is_wait(instr_set)) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else state <= EXECUTE;
                EXECUTE: if (!stall) begin
                    state       <= run ? FETCH : IDLE;
                    mem.mem_req <= run;
                end
                HALT: if (resume) begin
                    state       <= run ? FETCH : IDLE;
                    mem.mem_req <= run;
                    halted      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle check of the fetch sequencer
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        resume = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] instr_set;
    logic        decoder_en;
    logic [15:0] pc;
    logic        halted;
    int          passed = 0;
    int          total = 0;
    fetch_unit_if #(.ADDR_W(16)) bus ();
    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .resume        (resume),
        .mem           (bus.master),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr_set     (instr_set),
        .decoder_en    (decoder_en),
        .pc            (pc),
        .halted        (halted)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        tick();
        tick();
        chk("rst_req", {31'd0, bus.mem_req}, 0);
        chk("rst_den", {31'd0, decoder_en}, 1);
        chk("rst_halt", {31'd0, halted}, 0);
        chk("rst_pc", {16'd0, pc}, 0);
        chk("rst_addr", {16'd0, bus.mem_addr}, 0);
        chk("rst_ir", {16'd0, instr_set}, 0);
        reset = 1'b1;
        run   = 1'b1;
        tick();
        chk("c1_req", {31'd0, bus.mem_req}, 1);
        chk("c1_addr", {16'd0, bus.mem_addr}, 0);
        tick();
        chk("c2_req", {31'd0, bus.mem_req}, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h5123;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("c3_ir", {16'd0, instr_set}, 32'h5123);
        chk("c3_den", {31'd0, decoder_en}, 0);
        chk("c3_pc", {16'd0, pc}, 1);
        tick();
        chk("c4_den", {31'd0, decoder_en}, 1);
        chk("c4_req", {31'd0, bus.mem_req}, 0);
        tick();
        chk("c5_req", {31'd0, bus.mem_req}, 1);
        chk("c5_addr", {16'd0, bus.mem_addr}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'd0, bus.mem_req}, 0);
            chk("wait_addr", {16'd0, bus.mem_addr}, 1);
            chk("wait_den", {31'd0, decoder_en}, 1);
        end
        tick();
        chk("c9_den", {31'd0, decoder_en}, 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1234;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("c10_ir", {16'd0, instr_set}, 32'h1234);
        chk("c10_den", {31'd0, decoder_en}, 0);
        chk("c10_pc", {16'd0, pc}, 2);
        stall         = 1'b1;
        tick();
        branch_en     = 1'b1;
        branch_target = 16'h0080;
        tick();
        chk("stall_req", {31'd0, bus.mem_req}, 0);
        chk("stall_pc", {16'd0, pc}, 2);
        stall         = 1'b0;
        branch_en     = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_en = 1'b0;
        chk("br_req", {31'd0, bus.mem_req}, 1);
        chk("br_addr", {16'd0, bus.mem_addr}, 32'h0040);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hABCD;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("br_pc_inc", {16'd0, pc}, 32'h0041);
        branch_en     = 1'b1;
        branch_target = 16'hFFFF;
        tick();
        tick();
        branch_en = 1'b0;
        chk("ff_addr", {16'd0, bus.mem_addr}, 32'hFFFF);
        chk("ff_req", {31'd0, bus.mem_req}, 1);
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h0300;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("wrap_pc", {16'd0, pc}, 0);
        chk("wait_ir", {16'd0, instr_set}, 32'h0300);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("halt_on", {31'd0, halted}, 1);
        chk("halt_req", {31'd0, bus.mem_req}, 0);
        tick();
        chk("halt_hold", {31'd0, halted}, 1);
        chk("halt_pc", {16'd0, pc}, 0);
        tick();
        chk("halt_req2", {31'd0, bus.mem_req}, 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("res_halt", {31'd0, halted}, 0);
        chk("res_req", {31'd0, bus.mem_req}, 1);
        chk("res_addr", {16'd0, bus.mem_addr}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.mem_req}, 0);
        chk("arst_pc", {16'd0, pc}, 0);
        chk("arst_ir", {16'd0, instr_set}, 32'h0300 & 32'h0);
        tick();
        reset          = 1'b1;
        run            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hBEEF;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        chk("late_ir", {16'd0, instr_set}, 0);
        chk("late_pc", {16'd0, pc}, 0);
        chk("late_den", {31'd0, decoder_en}, 1);
        chk("late_req", {31'd0, bus.mem_req}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
